// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the OBI GPIO peripheral.
//   - byte offsets of the four registers (only addr[3:2] are decoded)
//   - per-pin mode and interrupt-trigger encodings
//   - small decode helpers for the two-bit mode / trigger fields
package gpio_pkg;

  localparam logic [3:0] GPIO_MODE = 4'h0;
  localparam logic [3:0] GPIO_INTR = 4'h4;
  localparam logic [3:0] GPIO_DATA = 4'h8;
  localparam logic [3:0] GPIO_PEND = 4'hC;

  // 2'b11 is also an input mode; only bit 1 matters for "is input".
  typedef enum logic [1:0] {
    MODE_Z   = 2'b00,
    MODE_OUT = 2'b01,
    MODE_IN  = 2'b10
  } gpio_mode_e;

  typedef enum logic [1:0] {
    TRIG_NONE = 2'b00,
    TRIG_RISE = 2'b01,
    TRIG_FALL = 2'b10,
    TRIG_BOTH = 2'b11
  } gpio_trig_e;

  function automatic logic mode_is_in(input logic [1:0] m);
    return m[1];
  endfunction

  function automatic logic trig_on_rise(input logic [1:0] t);
    return (t == TRIG_RISE) || (t == TRIG_BOTH);
  endfunction

  function automatic logic trig_on_fall(input logic [1:0] t);
    return (t == TRIG_FALL) || (t == TRIG_BOTH);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: one pad input brought into the clk_i domain.
//   clk_i, rst_i : clock, synchronous active-high reset
//   pad_i        : asynchronous pad value
//   sync_o       : synchronized pad value (after two flops)
//   rise_o/fall_o: single-cycle edge strobes, valid the cycle sync_o changes
module gpio_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability filter; p2: previous synchronized value
      sync_p0 <= pad_i;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign sync_o = sync_p1;
  assign rise_o = sync_p1 & ~prev_p2;
  assign fall_o = ~sync_p1 & prev_p2;

endmodule

// File: rtl/gpio_top_obi.sv
// gpio_top_obi: OBI slave GPIO block with up to 8 pins.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   gpio_oe_o/gpio_data_o  : pad output enable / value per pin
//   gpio_data_i            : asynchronous pad input per pin
//   irq_gpio0_o/1_o        : pending[0] / pending[1]
//   irq_gpio2_4_o/5_7_o    : OR of pending[4:2] / pending[7:5]
//   req_i,we_i,be_i,addr_i,data_i : OBI request channel (gnt_o = req_i)
//   rvalid_o, data_o       : OBI response, one cycle after each grant
// Registers: MODE 0x0, INTR 0x4, DATA 0x8, PEND 0xC (write-1-to-clear).
module gpio_top_obi
  import gpio_pkg::*;
#(
  parameter int GPIO_NUM = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  output logic [GPIO_NUM-1:0] gpio_data_o,
  input  logic [GPIO_NUM-1:0] gpio_data_i,
  output logic                irq_gpio0_o,
  output logic                irq_gpio1_o,
  output logic                irq_gpio2_4_o,
  output logic                irq_gpio5_7_o,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [31:0]         data_o
);

  localparam int MW = 2 * GPIO_NUM;

  logic [MW-1:0]       mode_q, mode_d, intr_q, intr_d;
  logic [GPIO_NUM-1:0] data_q, data_d, pend_q, pend_d;
  logic [GPIO_NUM-1:0] sync_w, rise_w, fall_w, evt_w, din_rd;
  logic [31:0]         bemask, rdata;
  logic [3:0]          off;
  logic                wr;
  logic [7:0]          pend8;
  logic                unused_bits;

  assign gnt_o  = req_i;
  assign off    = {addr_i[3:2], 2'b00};
  assign wr     = req_i & we_i;
  assign bemask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    gpio_sync_edge u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pad_i  (gpio_data_i[i]),
      .sync_o (sync_w[i]),
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i])
    );

    // Edges only count while the pin is configured as an input.
    assign evt_w[i] = mode_is_in(mode_q[2*i +: 2]) &
                      ((trig_on_rise(intr_q[2*i +: 2]) & rise_w[i]) |
                       (trig_on_fall(intr_q[2*i +: 2]) & fall_w[i]));

    assign gpio_oe_o[i] = (mode_q[2*i +: 2] == MODE_OUT);

    assign din_rd[i] = (mode_q[2*i +: 2] == MODE_OUT)   ? data_q[i] :
                       mode_is_in(mode_q[2*i +: 2])     ? sync_w[i] : 1'b0;
  end

  assign gpio_data_o = data_q;

  always_comb begin
    mode_d = mode_q;
    intr_d = intr_q;
    data_d = data_q;
    pend_d = pend_q;
    for (int b = 0; b < MW; b++) begin
      if (wr && off == GPIO_MODE && bemask[b]) mode_d[b] = data_i[b];
      if (wr && off == GPIO_INTR && bemask[b]) intr_d[b] = data_i[b];
    end
    for (int b = 0; b < GPIO_NUM; b++) begin
      if (wr && off == GPIO_DATA && bemask[b]) data_d[b] = data_i[b];
      if (wr && off == GPIO_PEND && bemask[b] && data_i[b]) pend_d[b] = 1'b0;
    end
    // A new edge overrides a same-cycle clear.
    pend_d = pend_d | evt_w;
  end

  // Read mux sees registered state, so PEND reads exclude same-cycle sets.
  always_comb begin
    rdata = '0;
    case (off)
      GPIO_MODE: rdata[MW-1:0]       = mode_q;
      GPIO_INTR: rdata[MW-1:0]       = intr_q;
      GPIO_DATA: rdata[GPIO_NUM-1:0] = din_rd;
      GPIO_PEND: rdata[GPIO_NUM-1:0] = pend_q;
      default:   rdata               = '0;
    endcase
  end

  // Register / response stage boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= '0;
      intr_q   <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      rvalid_o <= 1'b0;
      data_o   <= '0;
    end else begin
      mode_q   <= mode_d;
      intr_q   <= intr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      rvalid_o <= req_i;
      data_o   <= (req_i && !we_i) ? rdata : 32'h0;
    end
  end

  always_comb begin
    pend8 = '0;
    pend8[GPIO_NUM-1:0] = pend_q;
  end

  assign irq_gpio0_o   = pend8[0];
  assign irq_gpio1_o   = pend8[1];
  assign irq_gpio2_4_o = |pend8[4:2];
  assign irq_gpio5_7_o = |pend8[7:5];

endmodule

// File: tb/tb_gpio_top_obi.sv
module tb_gpio_top_obi;

  logic        clk = 0;
  logic        rst;
  logic [1:0]  gpio_oe, gpio_dout, gpio_din;
  logic        irq0, irq1, irq2_4, irq5_7;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        gnt, rvalid;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [31:0] exp;
    string       name;
  } item_t;
  item_t sb[$];

  gpio_top_obi #(.GPIO_NUM(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .gpio_oe_o     (gpio_oe),
    .gpio_data_o   (gpio_dout),
    .gpio_data_i   (gpio_din),
    .irq_gpio0_o   (irq0),
    .irq_gpio1_o   (irq1),
    .irq_gpio2_4_o (irq2_4),
    .irq_gpio5_7_o (irq5_7),
    .req_i         (req),
    .we_i          (we),
    .be_i          (be),
    .addr_i        (addr),
    .data_i        (wdata),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .data_o        (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rvalid must match the oldest outstanding request,
  // arrive in the cycle right after its grant, and carry the expected data.
  always @(negedge clk) begin
    if (rvalid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid with data 0x%08h, none outstanding", rdata);
      end else begin
        item_t it;
        it = sb.pop_front();
        if (rdata !== it.exp || cyc != it.cyc) begin
          n_fail++;
          $display("FAIL %s: data 0x%08h cycle %0d, required 0x%08h cycle %0d",
                   it.name, rdata, cyc, it.exp, it.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request (granted on the next edge); queue its expected response.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp, input string name);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    n_chk++;
    if (gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_%s: got %b, required 1", name, gnt);
    end
    @(posedge clk);
    #1;
    sb.push_back('{cyc, exp, name});
    req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    bus(1'b1, a, d, 4'hF, 32'h0, name);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, a, 32'h0, 4'h0, exp, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0; gpio_din = 2'b00;
    repeat (3) tick();
    rst = 0;
    chk("reset_oe", {30'h0, gpio_oe}, 32'h0);
    chk("reset_dout", {30'h0, gpio_dout}, 32'h0);
    chk("reset_irq", {28'h0, irq0, irq1, irq2_4, irq5_7}, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);

    // Reads of all offsets after reset, back-to-back
    rd(32'h0, 32'h0, "rst_mode");
    rd(32'h4, 32'h0, "rst_intr");
    rd(32'h8, 32'h0, "rst_data");
    rd(32'hC, 32'h0, "rst_pend");

    // Both pins output
    wr(32'h0, 32'h5, "wr_mode5");
    wr(32'h8, 32'h2, "wr_data2");
    chk("out_oe", {30'h0, gpio_oe}, 32'h3);
    chk("out_dout", {30'h0, gpio_dout}, 32'h2);
    rd(32'h8, 32'h2, "rd_data_out");

    // Byte enables
    wr(32'h0, 32'h0, "wr_mode0");
    bus(1'b1, 32'h0, 32'h4, 4'b0000, 32'h0, "wr_mode4_be0");
    rd(32'h0, 32'h0, "rd_mode_be0");
    bus(1'b1, 32'h0, 32'h4, 4'b0001, 32'h0, "wr_mode4_be1");
    rd(32'h0, 32'h4, "rd_mode_be1");
    chk("oe_pin1", {30'h0, gpio_oe}, 32'h2);

    // Unimplemented bits ignore writes
    wr(32'h4, 32'hFFFF_FFFF, "wr_intr_all");
    rd(32'h4, 32'hF, "rd_intr_masked");

    // Inputs, pin0 rising edge
    wr(32'h0, 32'hA, "wr_mode_in");
    wr(32'h4, 32'h1, "wr_intr_rise0");
    rd(32'h8, 32'h0, "rd_data_in0");
    gpio_din[0] = 1'b1;
    tick(); tick();
    chk("irq0_early", {31'h0, irq0}, 32'h0);
    tick();
    chk("irq0_rise", {31'h0, irq0}, 32'h1);
    rd(32'h8, 32'h1, "rd_data_in1");
    rd(32'hC, 32'h1, "rd_pend_rise");

    // W1C, then falling edge ignored on a rise-only pin
    wr(32'hC, 32'h1, "w1c_pin0");
    chk("irq0_cleared", {31'h0, irq0}, 32'h0);
    gpio_din[0] = 1'b0;
    repeat (4) tick();
    rd(32'hC, 32'h0, "rd_pend_fall_ignored");

    // Edge and W1C in the same cycle: set wins
    gpio_din[0] = 1'b1;
    tick(); tick();
    wr(32'hC, 32'h1, "w1c_same_cycle");
    chk("irq0_set_wins", {31'h0, irq0}, 32'h1);
    rd(32'hC, 32'h1, "rd_pend_set_wins");
    wr(32'hC, 32'h3, "w1c_all");

    // Pin1 both edges
    wr(32'h4, 32'hD, "wr_intr_both1");
    gpio_din[1] = 1'b1;
    tick(); tick();
    chk("irq1_early", {31'h0, irq1}, 32'h0);
    tick();
    chk("irq1_rise", {31'h0, irq1}, 32'h1);
    wr(32'hC, 32'h2, "w1c_pin1");
    chk("irq1_cleared", {31'h0, irq1}, 32'h0);
    gpio_din[1] = 1'b0;
    tick(); tick();
    rd(32'hC, 32'h0, "rd_pend_before_set");
    chk("irq1_fall", {31'h0, irq1}, 32'h1);
    rd(32'hC, 32'h2, "rd_pend_fall1");
    chk("irq_groups", {30'h0, irq2_4, irq5_7}, 32'h0);

    // MODE change keeps PEND; disabled pins read 0
    wr(32'h0, 32'h0, "wr_mode_off");
    rd(32'hC, 32'h2, "rd_pend_kept");
    rd(32'h8, 32'h0, "rd_data_disabled");

    // Reset coincident with a request drops its response
    req = 1'b1; we = 1'b0; addr = 32'hC; rst = 1'b1;
    tick();
    req = 1'b0;
    chk("rst_drops_rvalid", {31'h0, rvalid}, 32'h0);
    rst = 1'b0;
    chk("rst2_irq1", {31'h0, irq1}, 32'h0);
    chk("rst2_dout", {30'h0, gpio_dout}, 32'h0);
    rd(32'hC, 32'h0, "rd_pend_rst2");

    repeat (3) tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_rvalid: %0d responses outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
